// File: rtl/ldpc_rot_pkg.sv
// rtl/ldpc_rot_pkg.sv - shared constants and elaboration helpers for the LDPC circulant rotator
package ldpc_rot_pkg;

    localparam int WIDTH  = 360;
    localparam int SHW    = 9;
    localparam int NSTAGE = 9;

    // Number of set bits; used for pipeline depth and per-stage select delay.
    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    // FIFO must absorb every in-flight word plus one; a normalised shift must stay below WIDTH.
    function automatic bit rot_cfg_ok(input int fifo_depth, input int l, input int shw, input int width);
        return (fifo_depth >= l + 2) && ((1 << shw) <= 2 * width);
    endfunction

endpackage

// File: rtl/ldpc_rot_fifo.sv
// rtl/ldpc_rot_fifo.sv - first-word-fall-through output FIFO with occupancy count
module ldpc_rot_fifo #(
    parameter int WIDTH = 360,
    parameter int DEPTH = 6,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count
);
    import ldpc_rot_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign do_pop  = pop & valid;
    assign do_push = push & ((count < CW'(DEPTH)) | do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ldpc_rot_stage.sv
// rtl/ldpc_rot_stage.sv - fixed-value barrel stage, optionally registered
module ldpc_rot_stage #(
    parameter int WIDTH     = 360,
    parameter int SHIFT_VAL = 1,
    parameter bit REG       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    import ldpc_rot_pkg::*;

    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] rot_q;

    // Bit i takes bit (i + SHIFT_VAL) mod WIDTH when selected, otherwise passes through.
    always_comb begin
        rot = din;
        if (sel) begin
            for (int i = 0; i < WIDTH; i++) begin
                rot[i] = din[(i + SHIFT_VAL) % WIDTH];
            end
        end
    end

    // Output register; pruned by synthesis when the stage is combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= '0;
        end else begin
            rot_q <= rot;
        end
    end

    assign dout = REG ? rot_q : rot;

endmodule

// File: rtl/ldpc_rot_ctrl.sv
// rtl/ldpc_rot_ctrl.sv - staged variable rotator controller with credit-based output stream
module ldpc_rot_ctrl #(
    parameter int                WIDTH      = ldpc_rot_pkg::WIDTH,
    parameter int                SHW        = ldpc_rot_pkg::SHW,
    parameter int                NSTAGE     = ldpc_rot_pkg::NSTAGE,
    parameter logic [NSTAGE-1:0] REG_MASK   = NSTAGE'(9'b100010001),
    parameter int                FIFO_DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_shift,
    input  logic             err_clr,
    output logic             busy
);
    import ldpc_rot_pkg::*;

    localparam int L  = popcount(32'(REG_MASK));
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    if (!rot_cfg_ok(FIFO_DEPTH, L, SHW, WIDTH)) begin : g_cfg_err
        $error("ldpc_rot_ctrl: FIFO_DEPTH or SHW out of range");
    end

    logic              accept;
    logic              shift_ovf;
    logic [SHW-1:0]    s_norm;
    logic [SHW-1:0]    s_in;
    logic [NSTAGE-1:0] sel;
    logic [WIDTH-1:0]  stg [NSTAGE+1];
    logic              pipe_exit;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;

    assign accept = in_valid & in_ready;

    // Fold shifts >= WIDTH back into range; idle cycles present a zero shift to the stages.
    always_comb begin
        shift_ovf = (int'(in_shift) >= WIDTH);
        s_norm    = shift_ovf ? SHW'(int'(in_shift) - WIDTH) : in_shift;
        s_in      = accept ? s_norm : '0;
    end

    // Each select bit is delayed by the number of registered stages ahead of its stage.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_sel
        localparam int DK = popcount(32'(REG_MASK) & ((32'd1 << k) - 32'd1));
        if (DK == 0) begin : g_direct
            assign sel[k] = s_in[k];
        end else begin : g_delay
            logic [DK-1:0] dl;
            // Select delay line for this stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl <= '0;
                end else begin
                    dl <= (dl << 1) | DK'(s_in[k]);
                end
            end
            assign sel[k] = dl[DK-1];
        end
    end

    assign stg[0] = in_data;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        ldpc_rot_stage #(
            .WIDTH     (WIDTH),
            .SHIFT_VAL (1 << k),
            .REG       (REG_MASK[k])
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .sel  (sel[k]),
            .din  (stg[k]),
            .dout (stg[k+1])
        );
    end

    if (L == 0) begin : g_vp_none
        assign pipe_exit = accept;
    end else begin : g_vp
        logic [L-1:0] vp;
        // Valid marker travelling alongside the word through the registered stages.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vp <= '0;
            end else begin
                vp <= (vp << 1) | L'(accept);
            end
        end
        assign pipe_exit = vp[L-1];
    end

    // Words between accept and FIFO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({accept, pipe_exit})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky shift-range error; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_shift <= 1'b0;
        end else if (accept & shift_ovf) begin
            err_shift <= 1'b1;
        end else if (err_clr) begin
            err_shift <= 1'b0;
        end
    end

    ldpc_rot_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_exit),
        .din   (stg[NSTAGE]),
        .pop   (out_ready),
        .dout  (out_data),
        .valid (out_valid),
        .count (fifo_count)
    );

    // Credit only from registered occupancy, so a pop frees a slot one cycle later.
    assign in_ready = ~rst & ((inflight + fifo_count) < CW'(FIFO_DEPTH));
    assign busy     = (inflight != '0) | (fifo_count != '0);

endmodule
